// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//
// Receive half of the UART link. Deserializes the rx line (idle high, LSB
// first) into an 8-bit word with programmable data width (5..8), optional
// even/odd parity and one or two stop bits. Each completed word is presented
// on rx_data together with parity/frame error flags and a one-cycle rx_done
// pulse. rts_n tells the remote transmitter whether an unacknowledged word is
// being held; it is advisory only, so frames keep being received regardless.
//
// Optional feature macro:
//   UART_RX_SYNC_EN  - when defined, rx goes through a two-flop synchronizer
//                      (reset to 1) before use; every latency measured from
//                      the pin grows by two cycles. When undefined, rx must
//                      already be synchronous to clk.
//
// Parameters:
//   CLKS_PER_BIT     - clk cycles per bit period (even, >= 4), default 16
//
// Ports:
//   clk              - single clock, rising edge
//   reset            - asynchronous active-high reset
//   rx               - serial input
//   rts_n            - 0 = ready to receive, 1 = holding unacknowledged data
//   data_bit_num     - data bits: 00=5, 01=6, 10=7, 11=8
//   stop_bit_num     - 0 = one stop bit, 1 = two stop bits
//   parity_en        - 1 = parity bit follows the data bits
//   parity_type      - 0 = even, 1 = odd
//   rx_ack           - consumer has taken rx_data (single-cycle pulse)
//   rx_data          - last received word, unused MSBs are 0
//   rx_done          - one-cycle pulse: new word and flags valid
//   parity_error     - parity mismatch in the last word
//   frame_error      - a stop bit was sampled low in the last word
//   overrun          - a word completed while the previous one was unacked
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rts_n,
    input  logic [1:0] data_bit_num,
    input  logic       stop_bit_num,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       parity_error,
    output logic       frame_error,
    output logic       overrun
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Line as seen by the state machine (optionally synchronized).
    logic rxS;

`ifdef UART_RX_SYNC_EN
    // Two-flop synchronizer; resets to the idle level so no false start is
    // seen when reset is released.
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rxS = sync_q[1];
`else
    assign rxS = rx;
`endif

    // Frame tracking state.
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitIdx_q, bitIdx_d;
    logic          stopIdx_q, stopIdx_d;

    // Configuration latched at start confirmation so that mid-frame changes
    // on the shared configuration inputs cannot corrupt a word in flight.
    logic [1:0]    dataBits_q, dataBits_d;
    logic          twoStop_q, twoStop_d;
    logic          parEn_q, parEn_d;
    logic          parOdd_q, parOdd_d;

    // Word being assembled and its flags, before they are published.
    logic [7:0]    shift_q, shift_d;
    logic          parErrPend_q, parErrPend_d;
    logic          frmErrPend_q, frmErrPend_d;
    logic          donePend_q, donePend_d;

    // Published outputs.
    logic [7:0]    rxData_q, rxData_d;
    logic          rxDone_q, rxDone_d;
    logic          parityErr_q, parityErr_d;
    logic          frameErr_q, frameErr_d;
    logic          rtsN_q, rtsN_d;
    logic          overrun_q, overrun_d;

    // Index of the last data bit: 4 for 5-bit words up to 7 for 8-bit words.
    logic [2:0]    lastIdx;
    assign lastIdx = 3'd4 + {1'b0, dataBits_q};

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bitIdx_q     <= '0;
            stopIdx_q    <= 1'b0;
            dataBits_q   <= 2'b11;
            twoStop_q    <= 1'b0;
            parEn_q      <= 1'b0;
            parOdd_q     <= 1'b0;
            shift_q      <= '0;
            parErrPend_q <= 1'b0;
            frmErrPend_q <= 1'b0;
            donePend_q   <= 1'b0;
            rxData_q     <= '0;
            rxDone_q     <= 1'b0;
            parityErr_q  <= 1'b0;
            frameErr_q   <= 1'b0;
            rtsN_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bitIdx_q     <= bitIdx_d;
            stopIdx_q    <= stopIdx_d;
            dataBits_q   <= dataBits_d;
            twoStop_q    <= twoStop_d;
            parEn_q      <= parEn_d;
            parOdd_q     <= parOdd_d;
            shift_q      <= shift_d;
            parErrPend_q <= parErrPend_d;
            frmErrPend_q <= frmErrPend_d;
            donePend_q   <= donePend_d;
            rxData_q     <= rxData_d;
            rxDone_q     <= rxDone_d;
            parityErr_q  <= parityErr_d;
            frameErr_q   <= frameErr_d;
            rtsN_q       <= rtsN_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next-state logic. The bit counter runs from 0 to CLKS_PER_BIT-1 and a
    // sample is taken when it wraps; the first wrap after the start edge is
    // at half a bit, so every later sample lands mid-bit. The last stop
    // sample returns straight to IDLE and only flags donePend, which lets a
    // back-to-back start bit be caught while the word is being published.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bitIdx_d     = bitIdx_q;
        stopIdx_d    = stopIdx_q;
        dataBits_d   = dataBits_q;
        twoStop_d    = twoStop_q;
        parEn_d      = parEn_q;
        parOdd_d     = parOdd_q;
        shift_d      = shift_q;
        parErrPend_d = parErrPend_q;
        frmErrPend_d = frmErrPend_q;
        donePend_d   = 1'b0;
        rxData_d     = rxData_q;
        rxDone_d     = 1'b0;
        parityErr_d  = parityErr_q;
        frameErr_d   = frameErr_q;
        rtsN_d       = rtsN_q;
        overrun_d    = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (!rxS) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rxS) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = DATA;
                        dataBits_d   = data_bit_num;
                        twoStop_d    = stop_bit_num;
                        parEn_d      = parity_en;
                        parOdd_d     = parity_type;
                        bitIdx_d     = '0;
                        stopIdx_d    = 1'b0;
                        shift_d      = '0;
                        parErrPend_d = 1'b0;
                        frmErrPend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d             = '0;
                    shift_d[bitIdx_q] = rxS;
                    if (bitIdx_q == lastIdx) begin
                        state_d = parEn_q ? PARITY : STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    // Unused MSBs of shift_q are zero, so the reduction covers
                    // exactly the received data bits. Odd parity inverts.
                    parErrPend_d = (^shift_q) ^ rxS ^ parOdd_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (!rxS) begin
                        frmErrPend_d = 1'b1;
                    end
                    if (stopIdx_q == twoStop_q) begin
                        state_d    = IDLE;
                        donePend_d = 1'b1;
                    end else begin
                        stopIdx_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Publishing a word takes priority over an acknowledge arriving in
        // the same cycle; that ack is dropped and rts_n stays high.
        if (donePend_q) begin
            rxDone_d    = 1'b1;
            rxData_d    = shift_q;
            parityErr_d = parErrPend_q;
            frameErr_d  = frmErrPend_q;
            rtsN_d      = 1'b1;
            if (rtsN_q) begin
                overrun_d = 1'b1;
            end
        end else if (rx_ack && rtsN_q) begin
            rtsN_d    = 1'b0;
            overrun_d = 1'b0;
        end
    end

    assign rts_n        = rtsN_q;
    assign rx_data      = rxData_q;
    assign rx_done      = rxDone_q;
    assign parity_error = parityErr_q;
    assign frame_error  = frameErr_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
//
// Self-checking bench for uart_rx. Frames are driven bit by bit; every frame
// pushes its expected word, flags and completion cycle to a scoreboard queue,
// and a monitor pops and compares whenever rx_done is seen.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int C = 16;
    localparam int H = C / 2;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rts_n;
    logic [1:0] data_bit_num;
    logic       stop_bit_num;
    logic       parity_en;
    logic       parity_type;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       parity_error;
    logic       frame_error;
    logic       overrun;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         doneCyc;
    } exp_t;

    exp_t sbQ[$];

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;

    // Reference model of the handshake flags.
    logic mdlRts     = 1'b0;
    logic mdlOverrun = 1'b0;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .rts_n        (rts_n),
        .data_bit_num (data_bit_num),
        .stop_bit_num (stop_bit_num),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .overrun      (overrun)
    );

    // 10 ns clock and an edge counter used for latency checks.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Hard stop in case anything wedges.
    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every rx_done must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && rx_done) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected rx_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                logic expOv;
                e     = sbQ.pop_front();
                expOv = mdlRts ? 1'b1 : mdlOverrun;
                checkOutput("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                checkOutput("parity_error", {31'd0, parity_error}, {31'd0, e.perr});
                checkOutput("frame_error", {31'd0, frame_error}, {31'd0, e.ferr});
                checkOutput("done cycle", cyc, e.doneCyc);
                checkOutput("done rts_n", {31'd0, rts_n}, 32'd1);
                checkOutput("done overrun", {31'd0, overrun}, {31'd0, expOv});
                mdlOverrun = expOv;
                mdlRts     = 1'b1;
            end
        end
    end

    // Hold one bit on the line for a full bit period; starts and ends 1 time
    // unit after a rising edge.
    task automatic driveBit(input logic b);
        rx = b;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one complete frame and register its expected result.
    task automatic applyStimulus(input logic [7:0] data, input int nbits,
                                 input logic parEn, input logic parOdd,
                                 input logic parBit, input logic twoStop,
                                 input logic stop2Val, input logic expPerr,
                                 input logic expFerr);
        exp_t e;
        int   k;
        data_bit_num = 2'(nbits - 5);
        stop_bit_num = twoStop;
        parity_en    = parEn;
        parity_type  = parOdd;
        k            = nbits + (parEn ? 1 : 0) + (twoStop ? 2 : 1);
        e.data       = data & 8'((1 << nbits) - 1);
        e.perr       = expPerr;
        e.ferr       = expFerr;
        e.doneCyc    = cyc + 1 + H + k * C + 1 + SYNC_LAT;
        sbQ.push_back(e);
        driveBit(1'b0);
        for (int i = 0; i < nbits; i++) begin
            driveBit(data[i]);
        end
        if (parEn) begin
            driveBit(parBit);
        end
        driveBit(1'b1);
        if (twoStop) begin
            driveBit(stop2Val);
        end
        rx = 1'b1;
    endtask

    task automatic pulseAck();
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack     = 1'b0;
        mdlRts     = 1'b0;
        mdlOverrun = 1'b0;
        checkOutput("ack rts_n", {31'd0, rts_n}, 32'd0);
        checkOutput("ack overrun", {31'd0, overrun}, 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " rts_n"}, {31'd0, rts_n}, 32'd0);
        checkOutput({tag, " rx_done"}, {31'd0, rx_done}, 32'd0);
        checkOutput({tag, " rx_data"}, {24'd0, rx_data}, 32'd0);
        checkOutput({tag, " parity_error"}, {31'd0, parity_error}, 32'd0);
        checkOutput({tag, " frame_error"}, {31'd0, frame_error}, 32'd0);
        checkOutput({tag, " overrun"}, {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        rx           = 1'b1;
        rx_ack       = 1'b0;
        data_bit_num = 2'b11;
        stop_bit_num = 1'b0;
        parity_en    = 1'b0;
        parity_type  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        reset = 1'b0;
        idle(4);

        // 8N1 0xA5
        applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("A5 pending", sbQ.size(), 32'd0);
        checkOutput("A5 rts_n held", {31'd0, rts_n}, 32'd1);
        pulseAck();

        // 7E1, 0x35 has four ones: parity bit 1 is wrong, 0 is right
        applyStimulus(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("35 bad parity pending", sbQ.size(), 32'd0);
        pulseAck();
        applyStimulus(8'h35, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("35 good parity pending", sbQ.size(), 32'd0);
        pulseAck();

        // False start: low for 4 cycles only
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(3 * C);
        checkOutput("false start rts_n", {31'd0, rts_n}, 32'd0);
        checkOutput("false start rx_data", {24'd0, rx_data}, 32'h35);
        applyStimulus(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("3C pending", sbQ.size(), 32'd0);
        pulseAck();

        // 5 data bits, two stop bits, second stop low
        applyStimulus(8'h1F, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("1F pending", sbQ.size(), 32'd0);
        idle(2 * C);
        pulseAck();

        // Back-to-back 8N1 words without ack
        applyStimulus(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("b2b pending", sbQ.size(), 32'd0);
        checkOutput("b2b overrun", {31'd0, overrun}, 32'd1);
        checkOutput("b2b rx_data", {24'd0, rx_data}, 32'h22);
        pulseAck();

        // Reset in the middle of the data bits of 0xFF
        data_bit_num = 2'b11;
        stop_bit_num = 1'b0;
        parity_en    = 1'b0;
        driveBit(1'b0);
        driveBit(1'b1);
        driveBit(1'b1);
        driveBit(1'b1);
        reset = 1'b1;
        rx    = 1'b1;
        @(posedge clk);
        #1;
        checkResetValues("abort");
        reset      = 1'b0;
        mdlRts     = 1'b0;
        mdlOverrun = 1'b0;
        idle(2 * C);
        checkOutput("abort rx_data", {24'd0, rx_data}, 32'd0);
        applyStimulus(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("5A pending", sbQ.size(), 32'd0);
        pulseAck();
        idle(4);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver half of the UART link. Deserializes the `rx` line into `rx_data` with programmable data width, parity and stop bits, and reports `parity_error` and `frame_error`. Drives `rts_n` flow control toward the remote transmitter's `cts_n`. Sits beside the transmitter on the same `clk`, sharing the per-UART configuration signals.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per bit period; even, ≥4.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial input, idles high, LSB first.
- `rts_n`  out  1  0 = ready to receive; 1 = holding unacknowledged data.
- `data_bit_num`  in  2  data bits: 00=5, 01=6, 10=7, 11=8.
- `stop_bit_num`  in  1  0 = one stop bit, 1 = two stop bits.
- `parity_en`  in  1  1 = parity bit follows the data bits.
- `parity_type`  in  1  0 = even, 1 = odd.
- `rx_ack`  in  1  consumer has taken `rx_data`; single-cycle pulse.
- `rx_data`  out  8  received word; unused MSBs are 0.
- `rx_done`  out  1  one-cycle pulse: new word and flags valid.
- `parity_error`  out  1  parity mismatch for the last word.
- `frame_error`  out  1  a stop bit was sampled low in the last word.
- `overrun`  out  1  a word completed while the previous one was unacknowledged.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Sampling uses a bit counter (0..`CLKS_PER_BIT`-1), a bit index (0..7) and a stop index.
- IDLE: `rx`=0 sampled → START, counter cleared.
- START: after `CLKS_PER_BIT/2` cycles, resample `rx`.
  - 1 → false start, back to IDLE, no outputs change.
  - 0 → latch `data_bit_num`, `stop_bit_num`, `parity_en` and `parity_type`; go to DATA.
  - Configuration changes mid-frame are ignored.
- DATA: sample every `CLKS_PER_BIT` cycles (mid-bit) and shift in LSB first. After N data bits → PARITY if `parity_en`, else STOP.
- PARITY: one sample.
  - Even: error if XOR(data, parity bit) = 1.
  - Odd: error if XOR = 0.
  - With parity disabled, `parity_error` = 0.
- STOP: one or two samples. Any sample = 0 sets `frame_error`. After the last stop sample → IDLE immediately (mid-stop), so a start bit that follows back-to-back is caught.
- Word completion (the cycle after the last stop sample):
  - `rx_done`=1 for one cycle.
  - `rx_data`, `parity_error` and `frame_error` update and hold until the next completion.
  - `rts_n` → 1.
  - If `rts_n` was already 1, `overrun` → 1; the new data overwrites the old.
- `rx_ack` while `rts_n`=1: `rts_n` → 0 and `overrun` → 0 on the next edge.
- `rx_ack` in the same cycle as a completion: the completion wins; `rts_n` stays 1 and the ack is lost.
- Frames arriving while `rts_n`=1 are still received; `rts_n` is advisory.

## Timing
- Reset values: `rts_n`=0, `rx_done`=0, `rx_data`=0x00, `parity_error`=0, `frame_error`=0, `overrun`=0; state = IDLE.
- Reset asserted mid-frame aborts it; no `rx_done`.
- Let E0 be the edge at which `rx`=0 is first seen in IDLE. Let H=`CLKS_PER_BIT/2`, C=`CLKS_PER_BIT`, and K = N + parity + stops.
  - Start confirmation at E0+H.
  - Bit k (k=1..K) sampled at E0+H+k·C.
  - `rx_done` is high in the cycle after edge E0+H+K·C+1.
- Example: 8N1, C=16 → `rx_done` rises at edge E0+153.
- `rts_n` changes on the same edge as `rx_done` rises.

## Configuration
- `UART_RX_SYNC_EN` defined: `rx` passes through a two-flop synchronizer (reset value 1) before use. All latencies, measured from the pin, grow by 2 cycles.
- `UART_RX_SYNC_EN` not defined: `rx` feeds the state machine directly; the source must already be synchronous to `clk`.

## Test plan
- 8N1, C=16, send 0xA5 → `rx_done` at E0+153, `rx_data`=0xA5, both error flags 0, `rts_n`=1; `rx_ack` → `rts_n`=0 next cycle.
- 7 data bits, even parity, send 0x35 with parity bit 1 → `rx_data`=0x35, `parity_error`=1. Resend with parity bit 0 → `parity_error`=0.
- `rx` low for 4 cycles, then high → no `rx_done`, state returns to IDLE. A valid 0x3C sent afterwards → received correctly.
- 5 data bits, two stop bits, second stop driven 0, data 0x1F → `rx_data`=0x1F, `frame_error`=1.
- Two back-to-back 8N1 words (0x11, 0x22), no `rx_ack` → second `rx_done` gives `rx_data`=0x22, `overrun`=1. Then `rx_ack` → `overrun`=0, `rts_n`=0.
- Assert `reset` during DATA of 0xFF → all outputs return to reset values, no `rx_done`. The next word, 0x5A, is received correctly.
